// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and forwarding controller for the 5-stage F/D/E/M/W core.
//   It tracks the destination tags of the E, M and W stages itself, so the CPU
//   only presents decode-stage fields. It also handles a variable-latency data
//   memory with a wait timeout.
//
//   Optional feature macro: HAZ_PERF_CNT_EN
//     When defined, adds saturating stall_cnt/flush_cnt performance counters.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   valid_d                    D stage holds a real instruction
//   ra1_d, ra2_d, use1_d, use2_d   D source registers and their read enables
//   wa_d, regwrite_d           D destination register and its write enable
//   memtoreg_d, memwrite_d     D is a load / store
//   pcwrite_d                  D writes the PC register
//   cond_ok_e                  E condition passed (gates E side effects into M)
//   branch_e                   taken branch resolved in E
//   mem_ready_m                data memory completes the M access this cycle
//   fwd_a_e, fwd_b_e           00 regfile, 01 Result(W), 10 ALUOutM
//   stall_f/d/e/m              hold the stage register
//   flush_d/e/w                insert a bubble into the stage register
//   mem_err                    sticky flag: a memory wait hit MEM_TIMEOUT
//   stall_cnt, flush_cnt       perf counters (HAZ_PERF_CNT_EN only)
//
// FSM states
//   state | meaning
//   RUN   | pipeline advancing normally; wait counter held at zero
//   MWAIT | M-stage memory access outstanding; counting toward MEM_TIMEOUT
module hazard_scoreboard #(
    parameter int REG_AW      = 4,
    parameter int PC_REG      = 15,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] ra1_d,
    input  logic [REG_AW-1:0] ra2_d,
    input  logic              use1_d,
    input  logic              use2_d,
    input  logic [REG_AW-1:0] wa_d,
    input  logic              regwrite_d,
    input  logic              memtoreg_d,
    input  logic              memwrite_d,
    input  logic              pcwrite_d,
    input  logic              cond_ok_e,
    input  logic              branch_e,
    input  logic              mem_ready_m,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST_WAIT = TW'(MEM_TIMEOUT - 1);

    typedef enum logic {RUN, MWAIT} state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wa;
        logic              regWrite;
        logic              memToReg;
        logic              memOp;
        logic              pcWrite;
    } tag_t;

    tag_t              tagE;
    tag_t              tagM;
    logic [REG_AW-1:0] raE1;
    logic [REG_AW-1:0] raE2;

    // W only needs what forwarding and PC tracking look at.
    logic              wValid;
    logic [REG_AW-1:0] wWa;
    logic              wRegWrite;
    logic              wPcWrite;

    state_t            state;
    logic [TW-1:0]     waitCnt;

    logic timeout;
    logic memStall;
    logic loadUse;
    logic pcPending;

    assign timeout  = (state == MWAIT) && (waitCnt == LAST_WAIT);
    assign memStall = ((state == RUN) && tagM.valid && tagM.memOp && !mem_ready_m)
                    || ((state == MWAIT) && !mem_ready_m && !timeout);

    assign loadUse = tagE.valid && tagE.memToReg && tagE.regWrite
                   && ((use1_d && (ra1_d == tagE.wa)) || (use2_d && (ra2_d == tagE.wa)));

    assign pcPending = (valid_d && pcwrite_d)
                     || (tagE.valid && tagE.pcWrite)
                     || (tagM.valid && tagM.pcWrite)
                     || (wValid && wPcWrite);

    // Loads in M have no data yet, so only ALU results forward from M.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (raE1 != PC_IDX) begin
            if (tagM.valid && tagM.regWrite && !tagM.memToReg && (tagM.wa == raE1))
                fwd_a_e = 2'b10;
            else if (wValid && wRegWrite && (wWa == raE1))
                fwd_a_e = 2'b01;
        end
        if (raE2 != PC_IDX) begin
            if (tagM.valid && tagM.regWrite && !tagM.memToReg && (tagM.wa == raE2))
                fwd_b_e = 2'b10;
            else if (wValid && wRegWrite && (wWa == raE2))
                fwd_b_e = 2'b01;
        end
    end

    // A memory stall freezes F..M and bubbles W; it masks every other request.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (memStall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = loadUse || pcPending;
            stall_d = loadUse && !branch_e;
            flush_d = pcPending || branch_e;
            flush_e = loadUse || branch_e;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            waitCnt <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    waitCnt <= '0;
                    if (tagM.valid && tagM.memOp && !mem_ready_m)
                        state <= MWAIT;
                end
                MWAIT: begin
                    if (mem_ready_m) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (timeout) begin
                        state   <= RUN;
                        waitCnt <= '0;
                        mem_err <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + TW'(1);
                    end
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tagE      <= '0;
            tagM      <= '0;
            raE1      <= '0;
            raE2      <= '0;
            wValid    <= 1'b0;
            wWa       <= '0;
            wRegWrite <= 1'b0;
            wPcWrite  <= 1'b0;
        end else if (!memStall) begin
            wValid    <= tagM.valid;
            wWa       <= tagM.wa;
            wRegWrite <= tagM.regWrite;
            wPcWrite  <= tagM.pcWrite;

            // A failed condition keeps the slot but strips its side effects.
            tagM.valid    <= tagE.valid;
            tagM.wa       <= tagE.wa;
            tagM.memToReg <= tagE.memToReg;
            tagM.regWrite <= tagE.regWrite && cond_ok_e;
            tagM.memOp    <= tagE.memOp && cond_ok_e;
            tagM.pcWrite  <= tagE.pcWrite && cond_ok_e;

            if (flush_e || !valid_d) begin
                tagE <= '0;
                raE1 <= '0;
                raE2 <= '0;
            end else begin
                tagE.valid    <= 1'b1;
                tagE.wa       <= wa_d;
                tagE.regWrite <= regwrite_d;
                tagE.memToReg <= memtoreg_d;
                tagE.memOp    <= memtoreg_d || memwrite_d;
                tagE.pcWrite  <= pcwrite_d;
                raE1          <= ra1_d;
                raE2          <= ra2_d;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_e && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard (MEM_TIMEOUT=4). The driver sets the
//   decode-stage inputs for each cycle and queues the expected outputs; a
//   monitor on the falling edge pops and compares them.
//   Expected vector layout: {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e,
//   stall_m, flush_d, flush_e, flush_w, mem_err}.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       valid_d;
    logic [3:0] ra1_d;
    logic [3:0] ra2_d;
    logic       use1_d;
    logic       use2_d;
    logic [3:0] wa_d;
    logic       regwrite_d;
    logic       memtoreg_d;
    logic       memwrite_d;
    logic       pcwrite_d;
    logic       cond_ok_e;
    logic       branch_e;
    logic       mem_ready_m;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic       mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    hazard_scoreboard #(
        .REG_AW     (4),
        .PC_REG     (15),
        .MEM_TIMEOUT(4),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_d    (valid_d),
        .ra1_d      (ra1_d),
        .ra2_d      (ra2_d),
        .use1_d     (use1_d),
        .use2_d     (use2_d),
        .wa_d       (wa_d),
        .regwrite_d (regwrite_d),
        .memtoreg_d (memtoreg_d),
        .memwrite_d (memwrite_d),
        .pcwrite_d  (pcwrite_d),
        .cond_ok_e  (cond_ok_e),
        .branch_e   (branch_e),
        .mem_ready_m(mem_ready_m),
        .fwd_a_e    (fwd_a_e),
        .fwd_b_e    (fwd_b_e),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .stall_e    (stall_e),
        .stall_m    (stall_m),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .flush_w    (flush_w),
        .mem_err    (mem_err)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    localparam logic [11:0] IDLE   = 12'b00_00_0000_000_0;
    localparam logic [11:0] IDLE_E = 12'b00_00_0000_000_1;
    localparam logic [11:0] LU     = 12'b00_00_1100_010_0;
    localparam logic [11:0] MS     = 12'b00_00_1111_001_0;
    localparam logic [11:0] MS_E   = 12'b00_00_1111_001_1;
    localparam logic [11:0] PC_E   = 12'b00_00_1000_100_1;

    logic [11:0] expQ[$];
    string       nameQ[$];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [11:0] exp;
        logic [11:0] act;
        string       nm;
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            nm  = nameQ.pop_front();
            act = {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
                   flush_d, flush_e, flush_w, mem_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", nm, act, exp);
            end
        end
    end

    task automatic setD(input logic v, input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2, input logic [3:0] w,
                        input logic rw, input logic mtr, input logic mw, input logic pw);
        valid_d    = v;
        ra1_d      = r1;
        use1_d     = u1;
        ra2_d      = r2;
        use2_d     = u2;
        wa_d       = w;
        regwrite_d = rw;
        memtoreg_d = mtr;
        memwrite_d = mw;
        pcwrite_d  = pw;
    endtask

    task automatic nopD();
        setD(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick(input string nm, input logic [11:0] e);
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        cond_ok_e   = 1'b1;
        branch_e    = 1'b0;
        mem_ready_m = 1'b1;
        nopD();
        @(posedge clk);
        #1;

        tick("reset_outputs", IDLE);
        reset = 1'b1;

        // ALU forwarding: from M, then W-only
        setD(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 0); tick("add_r3_issue", IDLE);
        setD(1, 4'd3, 1, 4'd1, 1, 4'd5, 1, 0, 0, 0); tick("sub_in_d", IDLE);
        setD(1, 4'd4, 1, 4'd3, 1, 4'd6, 1, 0, 0, 0); tick("fwd_from_m", 12'b10_00_0000_000_0);
        nopD();                                      tick("fwd_from_w", 12'b00_01_0000_000_0);

        // Load-use: one bubble, then W forwarding
        setD(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 1, 0, 0); tick("ldr_issue", IDLE);
        setD(1, 4'd2, 1, 4'd1, 1, 4'd4, 1, 0, 0, 0); tick("load_use_stall", LU);
                                                     tick("load_use_bubble", IDLE);
        nopD();                                      tick("fwd_after_load", 12'b01_00_0000_000_0);

        // Branch while load-use is active
        setD(1, 4'd1, 1, 4'd0, 0, 4'd7, 1, 1, 0, 0); tick("ldr2_issue", IDLE);
        setD(1, 4'd7, 1, 4'd1, 1, 4'd8, 1, 0, 0, 0);
        branch_e = 1'b1;                             tick("branch_over_load_use", 12'b00_00_1000_110_0);
        branch_e = 1'b0;
        nopD();                                      tick("post_branch", IDLE);

        // Store waits three cycles on memory
        setD(1, 4'd1, 1, 4'd2, 1, 4'd0, 0, 0, 1, 0); tick("str_issue", IDLE);
        nopD();                                      tick("str_in_e", IDLE);
        mem_ready_m = 1'b0;
        tick("mem_wait1", MS);
        tick("mem_wait2", MS);
        tick("mem_wait3", MS);
        mem_ready_m = 1'b1;                          tick("mem_release", IDLE);

        // Load hits the timeout
        setD(1, 4'd1, 1, 4'd0, 0, 4'd9, 1, 1, 0, 0); tick("ldr3_issue", IDLE);
        nopD();                                      tick("ldr3_in_e", IDLE);
        mem_ready_m = 1'b0;
        for (int i = 0; i < 4; i++) tick($sformatf("timeout_wait%0d", i), MS);
        tick("timeout_release", IDLE);
        mem_ready_m = 1'b1;                          tick("mem_err_sticky", IDLE_E);
        mem_ready_m = 1'b0;                          tick("no_memop_no_stall", IDLE_E);
        mem_ready_m = 1'b1;

        // PC write squashed by condition in E
        setD(1, 4'd0, 0, 4'd0, 0, 4'd15, 1, 0, 0, 1); tick("pcw_in_d", PC_E);
        nopD();
        cond_ok_e = 1'b0;                             tick("pcw_in_e_nocond", PC_E);
        cond_ok_e = 1'b1;                             tick("pcw_squashed", IDLE_E);

        // PC write pending through W; r15 never forwarded
        setD(1, 4'd0, 0, 4'd0, 0, 4'd15, 1, 0, 0, 1); tick("pcw2_in_d", PC_E);
        setD(1, 4'd15, 1, 4'd0, 0, 4'd0, 0, 0, 0, 0); tick("pcw2_in_e", PC_E);
        nopD();                                       tick("pcw2_in_m_no_pc_fwd", PC_E);
                                                      tick("pcw2_in_w", PC_E);
                                                      tick("pcw2_retired", IDLE_E);

        // M takes priority over W
        setD(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 0); tick("add_a", IDLE_E);
                                                     tick("add_b", IDLE_E);
        setD(1, 4'd3, 1, 4'd3, 1, 4'd5, 1, 0, 0, 0); tick("sub_rr", IDLE_E);
        nopD();                                      tick("fwd_m_over_w", 12'b10_10_0000_000_1);

        // Reset during a memory wait
        setD(1, 4'd1, 1, 4'd0, 0, 4'd0, 0, 0, 1, 0); tick("str2_issue", IDLE_E);
        nopD();                                      tick("str2_in_e", IDLE_E);
        mem_ready_m = 1'b0;                          tick("mem_wait_pre_reset", MS_E);
        reset = 1'b0;                                tick("reset_mid_wait", IDLE);
        reset = 1'b1;                                tick("after_reset_no_stall", IDLE);
        mem_ready_m = 1'b1;

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
